// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver FSM states; RX_PARITY is only entered when parity is compiled in.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // 100 MHz system clock / 115200 baud.
    localparam int CLK_PER_BIT_DEF = 868;

    // Value presented on rd_data while the buffer is empty.
    localparam logic [7:0] RD_EMPTY = 8'h00;

endpackage

// File: rtl/uart_rx_buf_if.sv
// Core-side read port of the UART receive buffer (MMIO address 0).
interface uart_rx_buf_if;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    // Core / load unit side.
    modport master (
        output rd_en, clr_err,
        input  rd_data, rx_valid, overrun, frame_err, parity_err
    );

    // Receiver side.
    modport slave (
        input  rd_en, clr_err,
        output rd_data, rx_valid, overrun, frame_err, parity_err
    );
endinterface

// File: rtl/rx_fifo.sv
// Small first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO succeeds only if a pop happens in the same cycle;
// a pop on an empty FIFO is ignored even when a push arrives alongside it.
module rx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver (8 data bits, LSB first) feeding a receive FIFO for the
// data-memory MMIO port. Optional even parity: define UART_RX_PARITY_EN.
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int DEPTH       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    uart_rx_buf_if.slave  bus
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic          rxd_meta;
    logic          rxs;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push;
    logic          par_bad;
    logic          frame_err_q;
    logic          overrun_q;
    logic [7:0]    head;
    logic          empty;
    logic          full;
    logic          drop;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
`endif

    // Receive FSM: mid-bit sampling, registered push strobe and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push        <= 1'b0;
            par_bad     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
            // Clear first so a set later in this block wins.
            if (bus.clr_err) begin
                frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    par_bad <= 1'b0;
                    if (!rxs) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= RX_PARITY;
`else
                        if (bit_idx == 3'd7) state <= RX_STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= RX_STOP;
                        if (rxs != ^shreg) begin
                            par_bad      <= 1'b1;
                            parity_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            push  <= !par_bad;
                            state <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxs) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    rx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (bus.rd_en),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .drop      (drop)
    );

    // Sticky overrun: a byte was lost because the FIFO was full with no pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            if (bus.clr_err) overrun_q <= 1'b0;
            if (drop)        overrun_q <= 1'b1;
        end
    end

    // All outputs come from flops only; rxd never reaches them combinationally.
    assign bus.rx_valid  = !empty;
    assign bus.rd_data   = empty ? RD_EMPTY : head;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf with a queue-based reference model.
module tb_uart_rx_buf;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    // Frame cycle in which the byte is written: 2 sync flops + IDLE detect,
    // half a bit to mid-start, then one bit time per remaining frame bit, +1.
    localparam int PUSH_C = 3 + CPB / 2 + CPB * (NB - 1);

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    uart_rx_buf_if bus_if ();

    uart_rx_buf #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    logic [7:0] mq [$];
    bit   m_ovr = 1'b0;
    bit   m_fe  = 1'b0;
    bit   m_pe  = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Continuous comparison against the model while no frame is in flight.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] act;
            logic [11:0] exp;
            logic [7:0]  ed;
            ed  = (mq.size() != 0) ? mq[0] : 8'h00;
            exp = {(mq.size() != 0), ed, m_ovr, m_fe, m_pe};
            act = {bus_if.rx_valid, bus_if.rd_data, bus_if.overrun,
                   bus_if.frame_err, bus_if.parity_err};
            n_chk++;
            if (act !== exp) begin
                n_err++;
                if (n_err < 20)
                    $display("FAIL cycle_cmp t=%0t: got %03h want %03h", $time, act, exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        bus_if.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic clr();
        bus_if.clr_err = 1'b1;
        @(posedge clk);
        #1;
        bus_if.clr_err = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_pe  = 1'b0;
    endtask

    // Serialise one frame; pop_c >= 0 raises rd_en for that one frame cycle.
    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                        input int pop_c, output logic v_before, output logic v_after);
        logic fb [NB];
        bit   ok;
        chk_en   = 1'b0;
        v_before = 1'b0;
        v_after  = 1'b0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef UART_RX_PARITY_EN
        fb[9] = (^b) ^ par_flip;
`endif
        fb[NB-1] = stop_bit;
        for (int c = 0; c < CPB * NB; c++) begin
            rxd = fb[c / CPB];
            bus_if.rd_en = (c == pop_c);
            @(posedge clk);
            #1;
            bus_if.rd_en = 1'b0;
            if (c == PUSH_C - 1) v_before = bus_if.rx_valid;
            if (c == PUSH_C)     v_after  = bus_if.rx_valid;
        end
        rxd = 1'b1;
        ok = stop_bit && !(PAR && par_flip);
        if (!stop_bit)        m_fe = 1'b1;
        if (PAR && par_flip)  m_pe = 1'b1;
        if (pop_c >= 0 && mq.size() != 0) void'(mq.pop_front());
        if (ok) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else                   m_ovr = 1'b1;
        end
        chk_en = 1'b1;
    endtask

    logic vb, va;

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        bus_if.rd_en   = 1'b0;
        bus_if.clr_err = 1'b0;
        idle(4);
        rst = 1'b0;
        idle(200);
        chk("rst_valid",    {15'd0, bus_if.rx_valid},   16'd0);
        chk("rst_data",     {8'd0, bus_if.rd_data},     16'h0000);
        chk("rst_overrun",  {15'd0, bus_if.overrun},    16'd0);
        chk("rst_frame",    {15'd0, bus_if.frame_err},  16'd0);
        chk("rst_parity",   {15'd0, bus_if.parity_err}, 16'd0);
        chk_en = 1'b1;

        send(8'hA5, 1'b1, 1'b0, -1, vb, va);
        chk("a5_valid_before_push", {15'd0, vb}, 16'd0);
        chk("a5_valid_after_push",  {15'd0, va}, 16'd1);
        chk("a5_data",  {8'd0, bus_if.rd_data}, 16'h00A5);
        pop1();
        chk("a5_popped", {15'd0, bus_if.rx_valid}, 16'd0);

        // Four-clock low glitch must not start a frame.
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        chk("glitch_valid", {15'd0, bus_if.rx_valid}, 16'd0);

        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, 1'b0, -1, vb, va);
            idle(3);
        end
        chk("ovr_set", {15'd0, bus_if.overrun}, 16'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_readback", {8'd0, bus_if.rd_data}, 16'(i));
            pop1();
        end
        chk("ovr_drained", {15'd0, bus_if.rx_valid}, 16'd0);
        clr();
        chk("ovr_cleared", {15'd0, bus_if.overrun}, 16'd0);

        send(8'h3C, 1'b0, 1'b0, -1, vb, va);
        idle(10);
        chk("fe_set",   {15'd0, bus_if.frame_err}, 16'd1);
        chk("fe_valid", {15'd0, bus_if.rx_valid},  16'd0);
        send(8'h7E, 1'b1, 1'b0, -1, vb, va);
        idle(3);
        chk("after_fe_data", {8'd0, bus_if.rd_data}, 16'h007E);
        pop1();
        clr();
        chk("fe_cleared", {15'd0, bus_if.frame_err}, 16'd0);

        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1, 1'b0, -1, vb, va);
            idle(3);
        end
        send(8'h05, 1'b1, 1'b0, PUSH_C, vb, va);
        idle(3);
        chk("full_pop_push_ovr", {15'd0, bus_if.overrun}, 16'd0);
        for (int i = 2; i <= 5; i++) begin
            chk("full_pop_push_data", {8'd0, bus_if.rd_data}, 16'(i));
            pop1();
        end
        chk("full_pop_push_empty", {15'd0, bus_if.rx_valid}, 16'd0);

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b1, -1, vb, va);
        idle(3);
        chk("par_bad_flag",  {15'd0, bus_if.parity_err}, 16'd1);
        chk("par_bad_valid", {15'd0, bus_if.rx_valid},   16'd0);
        send(8'h03, 1'b1, 1'b0, -1, vb, va);
        idle(3);
        chk("par_ok_data", {8'd0, bus_if.rd_data}, 16'h0003);
        pop1();
        clr();
        chk("par_cleared", {15'd0, bus_if.parity_err}, 16'd0);
`else
        chk("parity_tied", {15'd0, bus_if.parity_err}, 16'd0);
`endif

        // Reset in the middle of a frame discards the buffered byte too.
        send(8'h55, 1'b1, 1'b0, -1, vb, va);
        chk("pre_rst_data", {8'd0, bus_if.rd_data}, 16'h0055);
        chk_en = 1'b0;
        rxd = 1'b0;
        idle(50);
        rst = 1'b1;
        rxd = 1'b1;
        idle(2);
        rst = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_pe  = 1'b0;
        chk("midframe_rst_valid", {15'd0, bus_if.rx_valid}, 16'd0);
        chk_en = 1'b1;
        idle(20);
        send(8'h5A, 1'b1, 1'b0, -1, vb, va);
        idle(3);
        chk("post_rst_data", {8'd0, bus_if.rd_data}, 16'h005A);
        pop1();
        idle(5);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
